agrupate: RTL and testbench
===========================

// Module: agrupate
// PURPOSE
//  Rebuilds GROUP_SIZE-wide result groups from a stream of results computed
//  only for unique operands. Each input word carries one result plus a
//  GROUP_SIZE x GROUP_SIZE repetition matrix that says which output lanes the
//  result fills. Sits after the unique-value compute stage and emits one full
//  group per completed set of unique results to the downstream consumer.
// PARAMETERS
//  DATA_WIDTH             16   bits per result / per output lane
//  GROUP_SIZE             4    lanes per output group
//  LOG_MAX_ITERS          16   width of num_iters
//  LOG_MAX_READS_PER_ITER 16   width of num_reads_per_iter
//  REP_INFO               GROUP_SIZE*GROUP_SIZE  repetition matrix bits
// PORTS
//  clk                 in   1   single clock, rising edge
//  rst                 in   1   asynchronous reset, active-high
//  configure           in   1   load run parameters (sampled in IDLE)
//  num_iters           in   LOG_MAX_ITERS           iterations per run
//  num_reads_per_iter  in   LOG_MAX_READS_PER_ITER  groups per iteration
//  data_in             in   DATA_WIDTH+REP_INFO  [DATA_WIDTH-1:0]=result, upper=matrix
//  valid_in            in   1   data_in valid
//  avail_out           out  1   block can accept data_in this cycle
//  data_out            out  GROUP_SIZE*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//  valid_out           out  1   data_out valid
//  avail_in            in   1   downstream can accept data_out
// BEHAVIOUR
//  - Reset: state=IDLE, avail_out=0, valid_out=0, data_out=0, counters/regs=0.
//  - IDLE: configure=1 latches num_iters, num_reads_per_iter; total groups
//    = num_iters*num_reads_per_iter (LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER bits).
//    Total 0 -> stay IDLE. Else go RUN. configure ignored outside IDLE.
//  - Matrix bit [r*GROUP_SIZE+c]=1: result for source row r is written to lane c.
//    Row r all-zero: row r is a repetition, no result arrives for it.
//  - Accept when valid_in && avail_out. First accept of a group latches the
//    matrix; later matrix fields in the same group are ignored.
//  - k-th accepted result of a group goes to the k-th non-zero row (ascending r),
//    written into every lane flagged in that row; a lane-filled mask is updated.
//  - Group completes on the accept that makes all lanes filled (or exhausts
//    non-zero rows; unfilled lanes then hold 0). Next cycle: data_out = group,
//    valid_out=1 (1-cycle latency); assembly regs cleared for the next group.
//  - valid_out/data_out held stable until avail_in=1; transfer on
//    valid_out && avail_in; valid_out drops next cycle unless a new group lands.
//  - avail_out = RUN && !(valid_out && !avail_in); stall never loses or
//    duplicates a group. Back-to-back groups sustain one group per cycle.
//  - Group counter increments per completed group; after the last group is
//    transferred, return to IDLE (avail_out=0).
//  - rst mid-run: immediate abort to reset state; partial group discarded.
//  - All-zero matrix on the first word: treated as row 0 = all lanes.
// TESTING
//  1 Reset: rst=1 -> avail_out=0, valid_out=0, data_out=0; rst=0, IDLE holds.
//  2 configure, iters=2, reads=4, G=4; each group: matrix diag except [2*4+2]=0,
//    bit[2]=1; results 1,2,3 -> data_out lanes {0..3}={1,2,1,3}, valid_out 1 cycle later.
//  3 Broadcast: matrix row0=4'b1111, result 7 -> one accept yields {7,7,7,7}.
//  4 avail_in=0 with group pending -> valid_out held, data_out stable,
//    avail_out=0; avail_in=1 -> one transfer, accepts resume next cycle.
//  5 Run of 8 groups completes -> after 8th transfer avail_out=0 (IDLE);
//    new configure restarts.
//  6 rst asserted after 2 of 3 results -> outputs zero; after re-configure,
//    next group holds no stale lanes.

Source files
------------

// File: rtl/agrupate.sv
// agrupate: rebuilds GROUP_SIZE-lane result groups from a stream of unique
// results. The repetition matrix carried by the first word of a group decides
// which lanes each incoming result fills.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for configure, no input accepted
// RUN   | assembling and emitting groups until the run count is done
module agrupate #(
  parameter int DATA_WIDTH             = 16,
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int REP_INFO               = GROUP_SIZE * GROUP_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 configure,
  input  logic [LOG_MAX_ITERS-1:0]             num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]    num_reads_per_iter,
  input  logic [DATA_WIDTH+REP_INFO-1:0]       data_in,
  input  logic                                 valid_in,
  output logic                                 avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]     data_out,
  output logic                                 valid_out,
  input  logic                                 avail_in
);

  localparam int TOT_W = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;
  localparam int ROW_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                          r_state;
  state_t                          w_state_nx;
  logic [TOT_W-1:0]                r_total;
  logic [TOT_W-1:0]                r_grp_cnt;
  logic [REP_INFO-1:0]             r_mat;
  logic                            r_started;
  logic [GROUP_SIZE-1:0]           r_filled;
  logic [GROUP_SIZE-1:0]           r_rows_done;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] r_lanes;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] r_data_out;
  logic                            r_valid_out;

  logic [TOT_W-1:0]                w_cfg_total;
  logic                            w_run_done;
  logic                            w_accept;
  logic [DATA_WIDTH-1:0]           w_result;
  logic [REP_INFO-1:0]             w_in_mat;
  logic [REP_INFO-1:0]             w_mat;
  logic [GROUP_SIZE-1:0]           w_row_ok;
  logic [ROW_W-1:0]                w_row_sel;
  logic                            w_found;
  logic [GROUP_SIZE-1:0]           w_row_lanes;
  logic [GROUP_SIZE-1:0]           w_sel_onehot;
  logic [GROUP_SIZE-1:0]           w_filled_nx;
  logic [GROUP_SIZE-1:0]           w_rows_left;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] w_lanes_nx;
  logic                            w_complete;

  assign w_cfg_total = TOT_W'(num_iters) * TOT_W'(num_reads_per_iter);
  assign w_run_done  = (r_grp_cnt == r_total);
  assign w_accept    = valid_in && avail_out;
  assign w_result    = data_in[DATA_WIDTH-1:0];
  // An all-zero matrix on the first word means a single broadcast result.
  assign w_in_mat    = (data_in[DATA_WIDTH +: REP_INFO] == '0)
                       ? REP_INFO'({GROUP_SIZE{1'b1}})
                       : data_in[DATA_WIDTH +: REP_INFO];
  assign w_mat       = r_started ? r_mat : w_in_mat;
  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state and input-side flow control; no accepts once every group is built
  always_comb begin
    w_state_nx = r_state;
    avail_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (configure && (w_cfg_total != '0)) w_state_nx = S_RUN;
      end
      S_RUN: begin
        avail_out = !w_run_done && !(r_valid_out && !avail_in);
        if (w_run_done && (!r_valid_out || avail_in)) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Pick the lowest non-zero matrix row not yet served and merge its lanes
  always_comb begin
    w_row_sel = '0;
    w_found   = 1'b0;
    w_row_ok  = '0;
    for (int r = 0; r < GROUP_SIZE; r++) begin
      w_row_ok[r] = (|w_mat[r*GROUP_SIZE +: GROUP_SIZE]) && !r_rows_done[r];
    end
    for (int r = 0; r < GROUP_SIZE; r++) begin
      if (w_row_ok[r] && !w_found) begin
        w_row_sel = ROW_W'(r);
        w_found   = 1'b1;
      end
    end
    w_row_lanes  = w_mat[w_row_sel*GROUP_SIZE +: GROUP_SIZE];
    w_sel_onehot = GROUP_SIZE'(1) << w_row_sel;
    w_filled_nx  = r_filled | w_row_lanes;
    w_rows_left  = w_row_ok & ~w_sel_onehot;
    w_lanes_nx   = r_lanes;
    for (int c = 0; c < GROUP_SIZE; c++) begin
      if (w_row_lanes[c]) w_lanes_nx[c*DATA_WIDTH +: DATA_WIDTH] = w_result;
    end
    w_complete = w_accept && ((&w_filled_nx) || (w_rows_left == '0));
  end

  // Run bookkeeping, group assembly and the output holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total     <= '0;
      r_grp_cnt   <= '0;
      r_mat       <= '0;
      r_started   <= 1'b0;
      r_filled    <= '0;
      r_rows_done <= '0;
      r_lanes     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && configure) begin
        r_total   <= w_cfg_total;
        r_grp_cnt <= '0;
      end
      if (r_valid_out && avail_in) r_valid_out <= 1'b0;
      if (w_complete) begin
        r_data_out  <= w_lanes_nx;
        r_valid_out <= 1'b1;
        r_grp_cnt   <= r_grp_cnt + TOT_W'(1);
        r_mat       <= '0;
        r_started   <= 1'b0;
        r_filled    <= '0;
        r_rows_done <= '0;
        r_lanes     <= '0;
      end else if (w_accept) begin
        r_mat       <= w_mat;
        r_started   <= 1'b1;
        r_filled    <= w_filled_nx;
        r_rows_done <= r_rows_done | w_sel_onehot;
        r_lanes     <= w_lanes_nx;
      end
    end
  end

endmodule

// File: tb/tb_agrupate.sv
// Testbench for agrupate: directed reset/flow-control scenarios plus
// randomized groups compared against a lane-filling reference model.
module tb_agrupate;

  logic        clk;
  logic        rst;
  logic        configure;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic [31:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [63:0] data_out;
  logic        valid_out;
  logic        avail_in;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  agrupate dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk non-empty rows in order, each consumes the next result,
  // stop once every lane is covered.
  function automatic void model_grp(input logic [15:0] mat_in, input logic [15:0] res [4],
                                    output logic [63:0] exp_o, output int n_o);
    logic [15:0] m;
    logic [3:0]  filled;
    logic [3:0]  row;
    m = (mat_in == 16'h0) ? 16'h000F : mat_in;
    filled = 4'h0;
    n_o = 0;
    exp_o = 64'h0;
    for (int r = 0; r < 4; r++) begin
      row = m[r*4 +: 4];
      if (row != 4'h0 && filled != 4'hF) begin
        for (int c = 0; c < 4; c++)
          if (row[c]) exp_o[c*16 +: 16] = res[n_o];
        filled = filled | row;
        n_o++;
      end
    end
  endfunction

  task automatic send_word(input logic [15:0] result, input logic [15:0] mat);
    logic take;
    int   cyc;
    take = 1'b0;
    cyc = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = {mat, result};
    while (!take && cyc < 500) begin
      #1 take = avail_out;
      @(posedge clk);
      if (!take) @(negedge clk);
      cyc++;
    end
    #1 valid_in = 1'b0;
    if (!take) check("send_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic send_group(input logic [15:0] mat, input logic [15:0] res [4], input int n);
    for (int k = 0; k < n; k++)
      send_word(res[k], (k == 0) ? mat : 16'($urandom));
  endtask

  task automatic do_configure(input logic [15:0] it, input logic [15:0] rd);
    @(negedge clk);
    configure = 1'b1;
    num_iters = it;
    num_reads_per_iter = rd;
    @(posedge clk);
    #1 configure = 1'b0;
  endtask

  function automatic logic [15:0] rand_mat();
    logic [15:0] m;
    case ($urandom_range(0, 3))
      0:       m = 16'h0;
      1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      2:       m = 16'h1 << $urandom_range(0, 15);
      default: m = 16'($urandom);
    endcase
    return m;
  endfunction

  task automatic run_random(input int ngroups);
    fork
      begin
        logic [15:0] res [4];
        logic [15:0] m;
        logic [63:0] e;
        int n;
        for (int g = 0; g < ngroups; g++) begin
          m = rand_mat();
          for (int k = 0; k < 4; k++) res[k] = 16'($urandom);
          model_grp(m, res, e, n);
          exp_q.push_back(e);
          send_group(m, res, n);
        end
      end
      begin
        int got;
        int cyc;
        logic stall_prev;
        logic [63:0] held;
        got = 0;
        cyc = 0;
        stall_prev = 1'b0;
        held = 64'h0;
        while (got < ngroups && cyc < 20000) begin
          @(negedge clk);
          avail_in = ($urandom_range(0, 3) != 0);
          #1 cyc++;
          if (stall_prev) begin
            check("hold_valid", 64'(valid_out), 64'd1);
            check("hold_data", data_out, held);
          end
          if (valid_out && !avail_in) check("stall_avail_out", 64'(avail_out), 64'd0);
          if (valid_out && avail_in) begin
            if (exp_q.size() == 0) check("extra_group", 64'd1, 64'd0);
            else begin
              check("grp_data", data_out, exp_q.pop_front());
              got++;
            end
          end
          stall_prev = valid_out && !avail_in;
          held = data_out;
        end
        if (got < ngroups) check("monitor_timeout", 64'(got), 64'(ngroups));
      end
    join
    avail_in = 1'b1;
  endtask

  initial begin
    logic [15:0] res [4];
    logic [63:0] e;
    int n;

    rst = 1'b1;
    configure = 1'b0;
    num_iters = 16'h0;
    num_reads_per_iter = 16'h0;
    data_in = 32'h0;
    valid_in = 1'b0;
    avail_in = 1'b1;

    // Reset values, then IDLE holds
    repeat (2) @(negedge clk);
    check("rst_avail_out", 64'(avail_out), 64'd0);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out", data_out, 64'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_avail_out", 64'(avail_out), 64'd0);
    check("idle_valid_out", 64'(valid_out), 64'd0);

    // Zero total keeps the block idle
    do_configure(16'd0, 16'd5);
    check("zero_total_idle", 64'(avail_out), 64'd0);

    // Run of 2x4 groups
    do_configure(16'd2, 16'd4);
    check("cfg_run", 64'(avail_out), 64'd1);

    // Group 1: diagonal with row 2 moved into row 0 -> {1,2,1,3}
    send_word(16'd1, 16'h8025);
    send_word(16'd2, 16'h1234);
    check("lat_before", 64'(valid_out), 64'd0);
    send_word(16'd3, 16'hFFFF);
    check("lat_valid", 64'(valid_out), 64'd1);
    check("grp1_data", data_out, {16'd3, 16'd1, 16'd2, 16'd1});

    // Group 2: broadcast of one result
    send_word(16'd7, 16'h000F);
    check("bcast_data", data_out, {4{16'd7}});
    @(posedge clk);
    #1 avail_in = 1'b0;

    // Group 3: held under back-pressure
    res[0] = 16'hA1; res[1] = 16'hB2; res[2] = 16'hC3; res[3] = 16'hD4;
    model_grp(16'h8421, res, e, n);
    send_group(16'h8421, res, n);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(valid_out), 64'd1);
      check("stall_data", data_out, e);
      check("stall_avail", 64'(avail_out), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    avail_in = 1'b1;
    #1 check("release_avail", 64'(avail_out), 64'd1);
    @(posedge clk);
    #1 check("release_drop", 64'(valid_out), 64'd0);

    // Remaining 5 groups randomized, then the run ends
    run_random(5);
    @(posedge clk);
    #1 check("run1_idle", 64'(avail_out), 64'd0);
    check("run1_no_valid", 64'(valid_out), 64'd0);

    // Fresh configure restarts
    do_configure(16'd3, 16'd4);
    check("run2_start", 64'(avail_out), 64'd1);
    run_random(12);
    @(posedge clk);
    #1 check("run2_idle", 64'(avail_out), 64'd0);

    // Reset mid-group discards the partial group
    do_configure(16'd1, 16'd2);
    send_word(16'h0111, 16'h0421);
    send_word(16'h0222, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_avail", 64'(avail_out), 64'd0);
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_data", data_out, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    do_configure(16'd1, 16'd1);
    res[0] = 16'h0055; res[1] = 16'h0066; res[2] = 16'h0; res[3] = 16'h0;
    model_grp(16'h0021, res, e, n);
    check("post_rst_count", 64'(n), 64'd2);
    send_group(16'h0021, res, n);
    check("post_rst_valid", 64'(valid_out), 64'd1);
    check("post_rst_data", data_out, e);
    @(posedge clk);
    #1 check("post_rst_idle", 64'(avail_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
